// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Purpose  : Shared constants and types for the mux_arb selector: mode
//            encodings, output-buffer state encoding and stats counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    localparam int STATS_W = 16;

endpackage
`default_nettype wire

// File: rtl/mux_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_if
// Purpose  : Bundles the mode/select controls, the per-channel input
//            handshakes and the output handshake of mux_arb.
// Ports    : modport slave  - seen by mux_arb
//            modport master - seen by the driver/consumer
//            mode, control, in_data, in_valid, in_ready,
//            out_data, out_src, out_valid, out_ready
// Revision : 1.0 - initial release
// ============================================================================
interface mux_arb_if
    import mux_arb_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic                     mode;
    logic [SEL_W-1:0]         control;
    logic [NUM_IN*WIDTH-1:0]  in_data;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_src;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  mode, control, in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output mode, control, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/mux_arb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_rr_picker
// Purpose  : Combinational round-robin picker. Returns the first channel with
//            valid set, searching ptr_i, ptr_i+1, ... modulo NUM_IN.
// Ports    : valid_i     - per-channel valid vector
//            ptr_i       - search start index
//            grant_o     - selected channel (0 when none valid)
//            any_valid_o - at least one channel valid
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_rr_picker
    import mux_arb_pkg::*;
#(
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] valid_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [SEL_W-1:0]  grant_o,
    output logic              any_valid_o
);

    // Scan from the farthest offset down to offset 0 so that the nearest
    // valid channel to the pointer is the last (winning) assignment.
    always_comb begin
        int w_idx;
        grant_o     = '0;
        any_valid_o = 1'b0;
        w_idx       = 0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            w_idx = int'(ptr_i) + i;
            if (w_idx >= NUM_IN) begin
                w_idx = w_idx - NUM_IN;
            end
            if (valid_i[w_idx]) begin
                grant_o     = SEL_W'(w_idx);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb
// Purpose  : N:1 datapath selector with per-channel valid/ready handshakes,
//            direct or round-robin selection and a registered 2-entry output
//            skid buffer (strict FIFO order, 1-cycle latency).
// Ports    : clk       - rising-edge clock
//            reset     - asynchronous active-high reset
//            bus       - mux_arb_if.slave (controls, inputs, output handshake)
//            acc_count - accept counter, saturating (only with
//                        MUX_ARB_STATS_EN defined)
// Config   : `define MUX_ARB_STATS_EN to add the acc_count port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              reset,
    mux_arb_if.slave          bus
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] acc_count
`endif
);

    localparam logic [SEL_W-1:0] C_LAST = SEL_W'(NUM_IN - 1);

    buf_state_t         state_q, state_d;
    logic               can_accept_q;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d;
    logic [WIDTH-1:0]   tail_data_q, tail_data_d;
    logic [SEL_W-1:0]   head_src_q, head_src_d;
    logic [SEL_W-1:0]   tail_src_q, tail_src_d;

    logic [SEL_W-1:0]   w_rr_grant;
    logic               w_any_valid;
    logic [SEL_W-1:0]   w_grant;
    logic [NUM_IN-1:0]  w_ready;
    logic [WIDTH-1:0]   w_grant_data;
    logic               w_acc;
    logic               w_drn;

    mux_arb_rr_picker #(
        .NUM_IN (NUM_IN)
    ) u_rr_picker (
        .valid_i     (bus.in_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (w_rr_grant),
        .any_valid_o (w_any_valid)
    );

    // Out-of-range direct selects fall through to the last channel, matching
    // the default arm of the legacy muxes.
    always_comb begin
        w_grant = bus.control;
        if (bus.mode == MODE_RR) begin
            w_grant = w_rr_grant;
        end else if (bus.control > C_LAST) begin
            w_grant = C_LAST;
        end
    end

    // in_ready depends only on registered state and the select inputs, never
    // on out_ready.
    always_comb begin
        w_ready          = '0;
        w_ready[w_grant] = can_accept_q & ((bus.mode == MODE_DIRECT) | w_any_valid);
    end

    assign w_grant_data = bus.in_data[int'(w_grant) * WIDTH +: WIDTH];
    assign w_acc        = bus.in_valid[w_grant] & w_ready[w_grant];
    assign w_drn        = (state_q != ST_EMPTY) & bus.out_ready;

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = head_data_q;
    assign bus.out_src   = head_src_q;

    // Buffer next-state: head is the FIFO front, tail is the second entry.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_src_d  = head_src_q;
        tail_data_d = tail_data_q;
        tail_src_d  = tail_src_q;
        rr_ptr_d    = rr_ptr_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_acc) begin
                    head_data_d = w_grant_data;
                    head_src_d  = w_grant;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_acc && w_drn) begin
                    head_data_d = w_grant_data;
                    head_src_d  = w_grant;
                end else if (w_acc) begin
                    tail_data_d = w_grant_data;
                    tail_src_d  = w_grant;
                    state_d     = ST_FULL;
                end else if (w_drn) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drn) begin
                    head_data_d = tail_data_q;
                    head_src_d  = tail_src_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (w_acc && (bus.mode == MODE_RR)) begin
            rr_ptr_d = (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            can_accept_q <= 1'b0;
            rr_ptr_q     <= '0;
            head_data_q  <= '0;
            head_src_q   <= '0;
            tail_data_q  <= '0;
            tail_src_q   <= '0;
        end else begin
            state_q      <= state_d;
            can_accept_q <= (state_d != ST_FULL);
            rr_ptr_q     <= rr_ptr_d;
            head_data_q  <= head_data_d;
            head_src_q   <= head_src_d;
            tail_data_q  <= tail_data_d;
            tail_src_q   <= tail_src_d;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [STATS_W-1:0] acc_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_count_q <= '0;
        end else if (w_acc && (acc_count_q != '1)) begin
            acc_count_q <= acc_count_q + 1'b1;
        end
    end

    assign acc_count = acc_count_q;
`endif

endmodule
`default_nettype wire
